// File: rtl/decoder_scan_driver.sv
// -----------------------------------------------------------------------------
// decoder_scan_driver
//
// Purpose:
//   Upstream sequencer for a 2-to-4 decoder with select inputs A (MSB), B (LSB)
//   and enable E. It steps a 2-bit channel through 0..3. Each channel owns a
//   slot of PRESCALE clock cycles. E is held low for the first BLANK cycles of
//   every slot so that the select lines settle before the decoder is enabled.
//   The block either scans continuously (run) or performs one four-slot sweep
//   (single).
//
// Parameters:
//   PRESCALE  clock cycles per slot, 2..65535
//   BLANK     cycles with E=0 at the start of each slot, 0..PRESCALE-1
//
// Ports:
//   clk            in   rising-edge system clock
//   rst_n          in   asynchronous active-low reset
//   run            in   level, 1 = scan continuously
//   single         in   pulse, request one sweep (honoured only while idle)
//   mask[3:0]      in   per-channel enable, mask[n]=0 keeps E low in slot n
//   a              out  select MSB (channel bit 1)
//   b              out  select LSB (channel bit 0)
//   e              out  decoder enable
//   slot_tick      out  1-cycle pulse on the first cycle of every slot
//   sweep_done     out  1-cycle pulse on the last cycle of slot 3
//   busy           out  high while a sweep is in progress
//   dbg_state      out  FSM state (0 = IDLE, 1 = SCAN)
//   dbg_ch[1:0]    out  current channel register
//   dbg_cnt[15:0]  out  current in-slot cycle counter
//   dbg_mode_run   out  run mode latched at the start of the current sweep
//
// Handshake / control semantics:
//   There is no valid/ready pair here. run is a level and single is a pulse;
//   both are sampled on the rising clock edge only while the FSM is IDLE. A
//   single pulse seen while busy (including the sweep_done cycle) is dropped,
//   not queued. At the end of slot 3 the level of run on that edge decides
//   between wrapping straight back to channel 0 and returning to IDLE.
// -----------------------------------------------------------------------------
module decoder_scan_driver #(
    parameter int PRESCALE = 4,
    parameter int BLANK    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        single,
    input  logic [3:0]  mask,
    output logic        a,
    output logic        b,
    output logic        e,
    output logic        slot_tick,
    output logic        sweep_done,
    output logic        busy,
    output logic        dbg_state,
    output logic [1:0]  dbg_ch,
    output logic [15:0] dbg_cnt,
    output logic        dbg_mode_run
);

    // The counter is sized for the largest legal PRESCALE so one width serves
    // every configuration.
    localparam logic [15:0] LAST_CNT = 16'(PRESCALE - 1);
    localparam logic [15:0] BLANK_C  = 16'(BLANK);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [1:0]  ch_q,    ch_d;
    logic [3:0]  mask_q,  mask_d;
    logic        mode_run_q, mode_run_d;

    // Next values of the registered outputs
    logic a_d, b_d, e_d, slot_tick_d, sweep_done_d, busy_d;

    logic slot_end;
    logic sweep_end;
    logic start_req;

    assign slot_end  = (cnt_q == LAST_CNT);
    assign sweep_end = slot_end && (ch_q == 2'd3);
    assign start_req = run || single;

    // -------------------------------------------------------------------------
    // Process 1: state register (plus the counters that move with it)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ch_q       <= '0;
            mask_q     <= '0;
            mode_run_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            mask_q     <= mask_d;
            mode_run_q <= mode_run_d;
        end
    end

    // -------------------------------------------------------------------------
    // Process 2: next-state logic
    // -------------------------------------------------------------------------
    // mask is captured on every edge that begins a slot, so a change that
    // arrives mid-slot only shows up from the following slot onwards.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        mask_d     = mask_q;
        mode_run_d = mode_run_q;

        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d    = SCAN;
                    cnt_d      = '0;
                    ch_d       = 2'd0;
                    mask_d     = mask;
                    mode_run_d = run;
                end
            end

            SCAN: begin
                if (!slot_end) begin
                    cnt_d = cnt_q + 16'd1;
                end else if (!sweep_end) begin
                    // Ordinary slot boundary inside a sweep.
                    cnt_d  = '0;
                    ch_d   = ch_q + 2'd1;
                    mask_d = mask;
                end else if (run) begin
                    // Continuous mode: wrap to channel 0 with no idle cycle.
                    cnt_d      = '0;
                    ch_d       = 2'd0;
                    mask_d     = mask;
                    mode_run_d = run;
                end else begin
                    // Sweep finished; the sweep is never cut short, the
                    // decision is taken only here.
                    state_d    = IDLE;
                    cnt_d      = '0;
                    ch_d       = 2'd0;
                    mode_run_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                ch_d    = 2'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Process 3: output logic
    // -------------------------------------------------------------------------
    // Outputs are computed from the next-state values and then registered, so
    // every output changes exactly on a clock edge together with the state it
    // describes and nothing from the input pins reaches an output pin without
    // passing a flop. With BLANK>=1 the select lines move on an edge where E
    // is being driven low; with BLANK=0 select and enable move on the same
    // edge.
    always_comb begin
        a_d          = 1'b0;
        b_d          = 1'b0;
        e_d          = 1'b0;
        slot_tick_d  = 1'b0;
        sweep_done_d = 1'b0;
        busy_d       = 1'b0;

        if (state_d == SCAN) begin
            a_d          = ch_d[1];
            b_d          = ch_d[0];
            e_d          = (cnt_d >= BLANK_C) && mask_d[ch_d];
            slot_tick_d  = (cnt_d == 16'd0);
            sweep_done_d = (cnt_d == LAST_CNT) && (ch_d == 2'd3);
            busy_d       = 1'b1;
        end
    end

    // Output registers; reset drives every output low immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a          <= 1'b0;
            b          <= 1'b0;
            e          <= 1'b0;
            slot_tick  <= 1'b0;
            sweep_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            a          <= a_d;
            b          <= b_d;
            e          <= e_d;
            slot_tick  <= slot_tick_d;
            sweep_done <= sweep_done_d;
            busy       <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Debug visibility
    // -------------------------------------------------------------------------
    assign dbg_state    = (state_q == SCAN);
    assign dbg_ch       = ch_q;
    assign dbg_cnt      = cnt_q;
    assign dbg_mode_run = mode_run_q;

endmodule
